// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: sizes, FSM encoding and the rotating search.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr+1 .. ptr+NUM_REQ (wrapping); the first set request wins.
  function automatic rr_pick_t rr_search(input logic [ADDR_W-1:0]  ptr,
                                         input logic [NUM_REQ-1:0] req_vec);
    rr_pick_t          pick;
    logic [ADDR_W-1:0] cand;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + ADDR_W'(i);
      if (!pick.found && req_vec[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// 2-to-4 decoder with enable: drives a one-hot vector from an address, all zero when disabled.
module grant_decoder
  import arb_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 4 requesters; the registered owner address/valid is decoded to a
// one-hot grant. An optional hold limit pre-empts a long-running owner and pulses hold_expired.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ADDR_W-1:0]  grant_addr,
  output logic               grant_valid,
  output logic               hold_expired
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               expired_q, expired_d;
  logic               owner_req;
  logic               hold_hit;
  logic [NUM_REQ-1:0] owner_mask;
  rr_pick_t           pick_idle;
  rr_pick_t           pick_hand;

  assign owner_req  = req[addr_q];
  assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
  assign owner_mask = NUM_REQ'(1) << addr_q;
  assign pick_idle  = rr_search(last_ptr_q, req);
  // On release or expiry the search restarts just after the owner, with the owner excluded.
  assign pick_hand  = rr_search(addr_q, req & ~owner_mask);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d    = GRANT;
          addr_d     = pick_idle.idx;
          hold_cnt_d = CNT_W'(1);
        end
      end
      GRANT: begin
        if (owner_req && !hold_hit) begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else begin
          last_ptr_d = addr_q;
          expired_d  = owner_req;
          if (pick_hand.found) begin
            addr_d     = pick_hand.idx;
            hold_cnt_d = CNT_W'(1);
          end else begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      last_ptr_q <= ADDR_W'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      expired_q  <= expired_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_addr   = addr_q;
  assign hold_expired = expired_q;

  grant_decoder u_dec (
    .addr_i (addr_q),
    .en_i   (grant_valid),
    .out_o  (grant)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench: dut_a uses MAX_HOLD=4, dut_b uses MAX_HOLD=0 (no limit).
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a = 4'b0000;
  logic [3:0] req_b = 4'b0000;
  logic [3:0] grant_a, grant_b;
  logic [1:0] addr_a, addr_b;
  logic       vld_a, vld_b, exp_a, exp_b;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .grant(grant_a),
    .grant_addr(addr_a), .grant_valid(vld_a), .hold_expired(exp_a)
  );

  rr_decode_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(grant_b),
    .grant_addr(addr_b), .grant_valid(vld_b), .hold_expired(exp_b)
  );

  typedef struct packed {
    logic       d;   // 0: dut_a, 1: dut_b
    logic [3:0] g;
    logic [1:0] a;
    logic       v;
    logic       x;
    logic       ca;  // compare address too
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  function automatic exp_t gnt(input logic d, input int idx, input logic ex);
    exp_t e;
    e.d = d;
    e.g = 4'b0001 << idx;
    e.a = 2'(idx);
    e.v = 1'b1;
    e.x = ex;
    e.ca = 1'b1;
    return e;
  endfunction

  function automatic exp_t idl(input logic d, input logic ex, input logic ca);
    exp_t e;
    e.d = d;
    e.g = 4'b0000;
    e.a = 2'd0;
    e.v = 1'b0;
    e.x = ex;
    e.ca = ca;
    return e;
  endfunction

  task automatic push(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive req at the falling edge; the response expected after the next rising edge is queued.
  task automatic step(input logic d, input logic [3:0] r, input exp_t e, input string nm);
    @(negedge clk);
    if (d) req_b = r;
    else   req_a = r;
    @(posedge clk);
    push(e, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    req_a = 4'b0000;
    req_b = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: samples shortly after each falling edge or an asynchronous reset assertion.
  initial begin
    exp_t e;
    string nm;
    logic [3:0] gg;
    logic [1:0] ga;
    logic gv, gx, ok;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        gg = e.d ? grant_b : grant_a;
        ga = e.d ? addr_b  : addr_a;
        gv = e.d ? vld_b   : vld_a;
        gx = e.d ? exp_b   : exp_a;
        ok = (gg == e.g) && (gv == e.v) && (gx == e.x) && (!e.ca || ga == e.a);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got grant=%b addr=%0d valid=%b expired=%b, want grant=%b addr=%0d valid=%b expired=%b",
                      nm, gg, ga, gv, gx, e.g, e.a, e.v, e.x);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state and idle after release
    #2;
    push(idl(1'b0, 1'b0, 1'b1), "reset_a");
    push(idl(1'b1, 1'b0, 1'b1), "reset_b");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, idl(1'b0, 1'b0, 1'b1), "idle_after_reset");

    // 2: first grant, then direct handoff, then idle
    step(1'b0, 4'b0101, gnt(1'b0, 0, 1'b0), "first_grant_0");
    step(1'b0, 4'b0100, gnt(1'b0, 2, 1'b0), "handoff_to_2");
    step(1'b0, 4'b0000, idl(1'b0, 1'b0, 1'b0), "release_to_idle");

    // 3: all requesting, rotation with expiry every 4 cycles
    do_reset();
    for (int k = 0; k < 20; k++)
      step(1'b0, 4'b1111, gnt(1'b0, (k / 4) % 4, (k % 4 == 0) && (k > 0)), "rotate_all");

    // 4: sole requester, one idle cycle on expiry
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) step(1'b0, 4'b0010, idl(1'b0, 1'b1, 1'b0), "sole_expiry_gap");
      else                  step(1'b0, 4'b0010, gnt(1'b0, 1, 1'b0), "sole_hold");
    end
    step(1'b0, 4'b0000, idl(1'b0, 1'b0, 1'b0), "sole_drop");

    // 4b: no hold limit, long ownership past counter saturation
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 4'b0010, gnt(1'b1, 1, 1'b0), "nolimit_hold");
    step(1'b1, 4'b0000, idl(1'b1, 1'b0, 1'b0), "nolimit_release");

    // 5: release coincides with a new request; search order after the owner wins
    do_reset();
    step(1'b0, 4'b1100, gnt(1'b0, 2, 1'b0), "owner2_grant");
    step(1'b0, 4'b1010, gnt(1'b0, 3, 1'b0), "order_after_2");
    step(1'b0, 4'b0010, gnt(1'b0, 1, 1'b0), "wrap_to_1");

    // 6: asynchronous reset mid-grant, then priority restarts at requester 0
    do_reset();
    step(1'b0, 4'b0100, gnt(1'b0, 2, 1'b0), "pre_async_grant");
    step(1'b0, 4'b0100, gnt(1'b0, 2, 1'b0), "pre_async_hold");
    @(negedge clk);
    #1;
    reset = 1'b1;
    req_a = 4'b1001;
    push(idl(1'b0, 1'b0, 1'b1), "async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    push(gnt(1'b0, 0, 1'b0), "post_reset_first_0");
    step(1'b0, 4'b1001, gnt(1'b0, 0, 1'b0), "post_reset_hold_0");
    step(1'b0, 4'b1000, gnt(1'b0, 3, 1'b0), "post_reset_to_3");

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
